// File: rtl/busperm_pkg.sv
// Shared types and constants for the bus permutator feeder.
// Lane geometry, pad value and packer FSM states.
package busperm_pkg;

  localparam int LANES = 8;
  localparam int SYMW  = 3;
  localparam int CTLW  = 16;

  localparam logic [SYMW-1:0] PAD = '0;

  typedef logic [LANES-1:0][SYMW-1:0] lane_vec_t;

  localparam lane_vec_t PAD_VEC = {LANES{PAD}};

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/busperm_out_slot.sv
// Single-entry valid/ready holding register for a packed word,
// its control vector and its symbol count.
module busperm_out_slot
  import busperm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  lane_vec_t             in_lanes,
  input  logic [CTLW-1:0]       in_ctl,
  input  logic [3:0]            in_cnt,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [LANES*SYMW-1:0] out_din,
  output logic [CTLW-1:0]       out_control,
  output logic [3:0]            out_count,
  output logic                  slot_free
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_din     <= '0;
      out_control <= '0;
      out_count   <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_din     <= in_lanes;
      out_control <= in_ctl;
      out_count   <= in_cnt;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/busperm_packer.sv
// Packs 3-bit symbols into 8-lane words for the bus permutator,
// binding each word to the control vector active at transfer.
module busperm_packer
  import busperm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic [SYMW-1:0]       sym_data,
  input  logic                  sym_last,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CTLW-1:0]       cfg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*SYMW-1:0] out_din,
  output logic [CTLW-1:0]       out_control,
  output logic [3:0]            out_count,
  output logic [15:0]           word_cnt
);

  state_t          state_q;
  state_t          state_n;
  logic [2:0]      cnt_q;
  logic [3:0]      hcnt_q;
  lane_vec_t       lanes_q;
  lane_vec_t       lanes_ins;
  lane_vec_t       load_lanes;
  logic [3:0]      load_cnt;
  logic [CTLW-1:0] shadow_q;
  logic            rdy_q;
  logic            accept;
  logic            complete;
  logic            load;
  logic            slot_free;

  assign cfg_ready = 1'b1;
  assign sym_ready = rdy_q;
  assign accept    = sym_valid && rdy_q;
  assign complete  = accept && ((cnt_q == 3'd7) || sym_last);

  // Lanes above the fill point already hold PAD from the last clear.
  always_comb begin
    lanes_ins = lanes_q;
    lanes_ins[cnt_q] = sym_data;
  end

  always_comb begin
    state_n    = state_q;
    load       = 1'b0;
    load_lanes = lanes_ins;
    load_cnt   = {1'b0, cnt_q} + 4'd1;
    unique case (state_q)
      FILL: begin
        if (complete) begin
          if (slot_free) load = 1'b1;
          else state_n = HOLD;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load       = 1'b1;
          load_lanes = lanes_q;
          load_cnt   = hcnt_q;
          state_n    = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      lanes_q  <= PAD_VEC;
      shadow_q <= '0;
      word_cnt <= '0;
    end else begin
      state_q <= state_n;
      rdy_q   <= (state_n == FILL);
      if (cfg_valid) shadow_q <= cfg_data;
      if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
      if (load) begin
        lanes_q <= PAD_VEC;
        cnt_q   <= '0;
      end else if (complete) begin
        lanes_q <= lanes_ins;
        hcnt_q  <= {1'b0, cnt_q} + 4'd1;
      end else if (accept) begin
        lanes_q <= lanes_ins;
        cnt_q   <= cnt_q + 3'd1;
      end
    end
  end

  // Shadow is sampled before this edge's cfg update lands.
  busperm_out_slot u_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .in_lanes    (load_lanes),
    .in_ctl      (shadow_q),
    .in_cnt      (load_cnt),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_din     (out_din),
    .out_control (out_control),
    .out_count   (out_count),
    .slot_free   (slot_free)
  );

endmodule

// File: tb/tb_busperm_packer.sv
// Directed bench for busperm_packer with an output scoreboard.
// Expected words are queued at stimulus time and popped on hand-off.
module tb_busperm_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sym_valid;
  logic        sym_ready;
  logic [2:0]  sym_data;
  logic        sym_last;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_din;
  logic [15:0] out_control;
  logic [3:0]  out_count;
  logic [15:0] word_cnt;

  typedef struct {
    logic [23:0] din;
    logic [15:0] ctl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [15:0] wc0;

  always #5 clk = ~clk;

  busperm_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_data    (sym_data),
    .sym_last    (sym_last),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_din     (out_din),
    .out_control (out_control),
    .out_count   (out_count),
    .word_cnt    (word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic [15:0] c,
                      input logic [3:0] n);
    exp_t e;
    e.din = d;
    e.ctl = c;
    e.cnt = n;
    q.push_back(e);
  endtask

  task automatic sym(input logic [2:0] d, input logic l);
    int n = 0;
    sym_valid = 1'b1;
    sym_data  = d;
    sym_last  = l;
    @(negedge clk);
    while (!sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (!sym_ready) chk("sym_accept_timeout", 32'(sym_ready), 32'd1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {8'h0, out_din}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_din", {8'h0, out_din}, {8'h0, e.din});
        chk("out_control", {16'h0, out_control}, {16'h0, e.ctl});
        chk("out_count", {28'h0, out_count}, {28'h0, e.cnt});
      end
    end
  end

  initial begin
    logic [23:0] w;
    logic [2:0]  s;
    rst_n = 1'b0;
    sym_valid = 0; sym_data = 0; sym_last = 0;
    cfg_valid = 0; cfg_data = 0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sym_ready", 32'(sym_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // full word, symbols 0..7
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(24'hFAC688, 16'h0, 4'd8);
      sym(3'(i), 1'b0);
    end
    @(negedge clk);
    chk("full_latency_valid", 32'(out_valid), 32'd1);
    cyc(2);

    // short word 5,6,7 with last
    push(24'h0001F5, 16'h0, 4'd3);
    sym(3'd5, 1'b0);
    sym(3'd6, 1'b0);
    sym(3'd7, 1'b1);
    cyc(2);

    // cfg with completing symbol binds to the next word
    sym(3'd1, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 16'hA5A5;
    push(24'h000011, 16'h0000, 4'd2);
    sym(3'd2, 1'b1);
    cfg_valid = 1'b0;
    push(24'h000003, 16'hA5A5, 4'd1);
    sym(3'd3, 1'b1);
    cyc(3);

    // backpressure into HOLD, cfg during HOLD
    wc0 = word_cnt;
    out_ready = 1'b0;
    push(24'h00002C, 16'hA5A5, 4'd2);
    sym(3'd4, 1'b0);
    sym(3'd5, 1'b1);
    push(24'h00003E, 16'h1234, 4'd2);
    sym(3'd6, 1'b0);
    sym(3'd7, 1'b1);
    @(negedge clk);
    chk("hold_sym_ready", 32'(sym_ready), 32'd0);
    chk("hold_out_din", {8'h0, out_din}, 32'h2C);
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    cfg_valid = 1'b1;
    cfg_data  = 16'h1234;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    cyc(4);
    chk("bp_word_cnt", 32'(word_cnt), 32'(wc0 + 16'd2));
    chk("bp_sym_ready", 32'(sym_ready), 32'd1);

    // throughput: 64 back-to-back symbols
    wc0 = word_cnt;
    stalls = 0;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      s = 3'((i * 5 + 3) % 8);
      w[(i % 8) * 3 +: 3] = s;
      if (i % 8 == 7) push(w, 16'h1234, 4'd8);
      sym(s, 1'b0);
    end
    cyc(3);
    chk("tput_stalls", 32'(stalls), 32'd0);
    chk("tput_word_cnt", 32'(word_cnt), 32'(wc0 + 16'd8));

    // reset with a held output word and a partial word
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) sym(3'd6, 1'b0);
    sym(3'd1, 1'b0);
    sym(3'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_din", {8'h0, out_din}, 32'h0);
    chk("mrst_out_control", 32'(out_control), 32'd0);
    chk("mrst_out_count", 32'(out_count), 32'd0);
    chk("mrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("mrst_sym_ready", 32'(sym_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(24'h000003, 16'h0, 4'd1);
    sym(3'd3, 1'b1);
    cyc(3);
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
